// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both sides, {Z,N,C,V} flags,
// variable barrel shifts and an NBIT-step shift-add multiplier.
module seq_alu #(
  parameter int NBIT = 16,
  parameter int SHW  = $clog2(NBIT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] A,
  input  logic [NBIT-1:0] B,
  input  logic [3:0]      Sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] num_out,
  output logic [3:0]      flags,
  output logic            op_err
);

  localparam int M  = NBIT - 1;
  localparam int CW = $clog2(NBIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBIT);
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [2*NBIT-1:0] mcand;
  logic [2*NBIT-1:0] acc;
  logic [NBIT-1:0]   mplier;
  logic [CW-1:0]     cnt;

  logic            accept;
  logic [SHW-1:0]  sh;
  logic [NBIT:0]   sum, diff, shl_ext, shr_ext, asr_ext;
  logic [NBIT-1:0] res;
  logic            c, v, z, n, err;
  logic [3:0]      flags_next;

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign sh       = B[SHW-1:0];

  // One extra bit on each shift catches the last bit shifted out as the carry.
  assign sum     = {1'b0, A} + {1'b0, B};
  assign diff    = {1'b0, A} + {1'b0, ~B} + (NBIT+1)'(1);
  assign shl_ext = {1'b0, A} << sh;
  assign shr_ext = {A, 1'b0} >> sh;
  assign asr_ext = $signed({A, 1'b0}) >>> sh;

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    err = 1'b0;
    case (Sel)
      4'd0: begin
        res = sum[M:0];
        c   = sum[NBIT];
        v   = (A[M] == B[M]) && (res[M] != A[M]);
      end
      4'd1: begin
        res = diff[M:0];
        c   = diff[NBIT];
        v   = (A[M] != B[M]) && (res[M] != A[M]);
      end
      4'd2: res = A & B;
      4'd3: res = A | B;
      4'd4: res = A ^ B;
      4'd5: res = ~A;
      4'd6: begin
        res = shl_ext[M:0];
        c   = shl_ext[NBIT];
      end
      4'd7: begin
        res = shr_ext[NBIT:1];
        c   = shr_ext[0];
      end
      4'd8: begin
        res = asr_ext[NBIT:1];
        c   = asr_ext[0];
      end
      4'd9: res = (A << sh) | (A >> (NBIT - int'(sh)));
      OP_CMP: begin
        c = diff[NBIT];
        v = (A[M] != B[M]) && (diff[M] != A[M]);
      end
      OP_MUL: res = '0;
      default: err = 1'b1;
    endcase
    z = (Sel == OP_CMP) ? (diff[M:0] == '0) : (res == '0);
    n = (Sel == OP_CMP) ? diff[M] : res[M];
    flags_next = err ? 4'b0000 : {z, n, c, v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_out   <= '0;
      flags     <= '0;
      op_err    <= 1'b0;
      out_valid <= 1'b0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept && Sel == OP_MUL) begin
            state     <= BUSY;
            out_valid <= 1'b0;
            mcand     <= {{NBIT{1'b0}}, A};
            mplier    <= B;
            acc       <= '0;
            cnt       <= '0;
          end else if (accept) begin
            state     <= DONE;
            out_valid <= 1'b1;
            num_out   <= (Sel == OP_CMP) ? '0 : res;
            flags     <= flags_next;
            op_err    <= err;
          end else if (state == DONE && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          // NBIT add steps, then one cycle to publish the product.
          if (cnt == CNT_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            num_out   <= acc[M:0];
            flags     <= {acc[M:0] == '0, acc[M], |acc[2*NBIT-1:NBIT], 1'b0};
            op_err    <= 1'b0;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: the driver queues expected results on issue,
// a negedge monitor pops and compares every transferred result.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [3:0]  Sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] num_out;
  logic [3:0]  flags;
  logic        op_err;

  seq_alu #(.NBIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Sel(Sel), .out_valid(out_valid), .out_ready(out_ready),
    .num_out(num_out), .flags(flags), .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] num;
    logic [3:0]  flg;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("result num_out=%h flags=%b op_err=%b (want %h %b %b)",
                 num_out, flags, op_err, mon_e.num, mon_e.flg, mon_e.err);
        check("num_out", num_out, mon_e.num);
        check("flags", flags, mon_e.flg);
        check("op_err", op_err, mon_e.err);
      end
    end
  end

  task automatic issue(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] en, input logic [3:0] ef, input logic ee,
                       output int waits);
    @(negedge clk);
    Sel = s; A = a; B = b; in_valid = 1'b1; waits = 0;
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{num: en, flg: ef, err: ee});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Single-cycle ops must show out_valid right after the accept edge.
  task automatic run(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] en, input logic [3:0] ef, input logic ee);
    int w;
    issue(s, a, b, en, ef, ee, w);
    check("latency1", out_valid, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int w, n, tw;
    logic ok;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_num_out", num_out, 32'd0);
    check("rst_flags", flags, 32'd0);
    check("rst_op_err", op_err, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    //   sel    A         B         num       ZNCV     err
    run(4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b0);
    run(4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 1'b0);
    run(4'd10, 16'h0005, 16'h0005, 16'h0000, 4'b1010, 1'b0);
    run(4'd8,  16'h8010, 16'h0004, 16'hF801, 4'b0100, 1'b0);
    run(4'd9,  16'h8001, 16'h0001, 16'h0003, 4'b0000, 1'b0);
    run(4'd6,  16'h1234, 16'h0000, 16'h1234, 4'b0000, 1'b0);
    run(4'd6,  16'hC000, 16'h0001, 16'h8000, 4'b0110, 1'b0);
    run(4'd6,  16'h0001, 16'h0021, 16'h0002, 4'b0000, 1'b0);
    run(4'd7,  16'h0003, 16'h0001, 16'h0001, 4'b0010, 1'b0);
    run(4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b0);
    run(4'd1,  16'h0001, 16'h0002, 16'hFFFF, 4'b0100, 1'b0);
    run(4'd10, 16'h0003, 16'h0005, 16'h0000, 4'b0100, 1'b0);
    run(4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 1'b0);
    run(4'd3,  16'h8000, 16'h0001, 16'h8001, 4'b0100, 1'b0);
    run(4'd4,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 1'b0);
    run(4'd5,  16'h0000, 16'h0000, 16'hFFFF, 4'b0100, 1'b0);
    run(4'd13, 16'h1111, 16'h2222, 16'h0000, 4'b0000, 1'b1);

    // MUL with garbage on the inputs during BUSY (must be ignored/uncaptured).
    issue(4'd11, 16'd300, 16'd300, 16'h5F90, 4'b0010, 1'b0, w);
    A = 16'hDEAD; B = 16'hBEEF; Sel = 4'd0; in_valid = 1'b1;
    n = 0; ok = 1'b1;
    while (!out_valid && n < 40) begin
      if (in_ready) ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("mul_latency", n, 32'd17);
    check("mul_busy_in_ready", ok, 32'd1);

    issue(4'd11, 16'd3, 16'd5, 16'h000F, 4'b0000, 1'b0, w);
    issue(4'd11, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 1'b0, w);
    drain();

    // Back-pressure: result must hold for 5 cycles with in_ready low.
    out_ready = 1'b0;
    issue(4'd0, 16'h1234, 16'h1111, 16'h2345, 4'b0000, 1'b0, w);
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (num_out !== 16'h2345 || flags !== 4'b0000 || in_ready !== 1'b0 || out_valid !== 1'b1)
        ok = 1'b0;
    end
    check("stall_stable", ok, 32'd1);
    out_ready = 1'b1;

    tw = 0;
    for (int i = 0; i < 4; i++) begin
      issue(4'd0, 16'(i), 16'h0100, 16'h0100 + 16'(i), 4'b0000, 1'b0, w);
      tw += w;
      check("b2b_valid", out_valid, 32'd1);
    end
    check("b2b_waits", tw, 32'd0);
    drain();

    // Reset in the middle of a multiply.
    issue(4'd0, 16'h4321, 16'h0000, 16'h4321, 4'b0000, 1'b0, w);
    issue(4'd11, 16'd7, 16'd9, 16'd63, 4'b0000, 1'b0, w);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", out_valid, 32'd0);
    check("midrst_num_out", num_out, 32'd0);
    check("midrst_flags", flags, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    check("midrst_no_result", ok, 32'd1);

    run(4'd13, 16'h0001, 16'h0001, 16'h0000, 4'b0000, 1'b1);
    run(4'd0,  16'h0002, 16'h0003, 16'h0005, 4'b0000, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
